mips_regfile: RTL and testbench
===============================

// Module: mips_regfile
// PURPOSE
//  Parametrised general-purpose register file for the 32-bit MIPS datapath.
//  - Provides NUM_RD registered read ports and two clocked write ports.
//  - Write port A carries the ALU result; write port M carries load data from the memory block.
//  - Sits between the decoder (addresses), the ALU and memory (write data) and the ALU inputs (read data).
//  - Clears its array after reset with a hardware sweep and raises rdy when done.
// PARAMETERS
//  DATA_W  32  register width in bits
//  DEPTH   32  number of registers; must be a power of two, DEPTH >= 2
//  NUM_RD   2  number of read ports, 1..4
//  AW      $clog2(DEPTH)  address width; localparam, not overridable
// PORTS
//  clk      in   1              single clock; all logic on rising edge
//  rst_n    in   1              synchronous, active-low reset
//  rd_addr  in   NUM_RD*AW      packed read addresses; port k = [k*AW +: AW]
//  rd_data  out  NUM_RD*DATA_W  packed registered read data; port k = [k*DATA_W +: DATA_W]
//  wa_en    in   1              ALU write enable
//  wa_addr  in   AW             ALU write address (Rd)
//  wa_data  in   DATA_W         ALU result
//  wm_en    in   1              load write enable (opcode 6'b100011 decoded upstream)
//  wm_addr  in   AW             load write address (Rt)
//  wm_data  in   DATA_W         memory output
//  rdy      out  1              1 = array cleared, ports live
// BEHAVIOUR
//  - Reset: rst_n low at any rising edge, including mid-sweep or mid-write:
//    - state <= INIT, clr_idx <= 0, rd_data <= 0, rdy <= 0.
//    - A write presented on that edge is discarded.
//  - FSM INIT:
//    - Writes 0 to entry clr_idx and increments clr_idx each cycle.
//    - wa_en/wm_en are ignored; rd_data stays 0.
//    - On the cycle clr_idx == DEPTH-1: go to RUN; rdy = 1 from the next edge.
//    - Sweep takes DEPTH cycles after rst_n returns high.
//  - FSM RUN: stays in RUN until reset. No other transitions.
//  - Writes (RUN only):
//    - Committed at the rising edge where the enable is high.
//    - A and M to different addresses: both commit.
//    - A and M to the same address: M wins.
//  - Reads:
//    - Latency 1: rd_data[k] after edge N = entry rd_addr[k] as sampled at edge N.
//    - Write-first bypass: includes any write committed at edge N, with the same M-over-A priority.
//    - All read ports are independent; any number may read the same address.
//  - No arithmetic; data passes through unmodified at DATA_W bits.
// CONFIGURATION
//  ZERO_REG_EN defined:
//    - Entry 0 reads as 0 on every port, bypass included.
//    - Writes to address 0 are dropped.
//    - Same-address A/M priority is irrelevant for entry 0.
//  ZERO_REG_EN undefined: entry 0 is an ordinary register.
// STRUCTURE
//  - Package mips_regfile_pkg holds:
//    - typedef enum state_t {INIT, RUN}
//    - the LOAD_OPC = 6'b100011 constant used by the upstream decode
//  - Sub-module mips_regfile_clr holds the INIT sweep counter and rdy generation.
//    - Outputs: clr_we, clr_idx, rdy.
//  - The top level holds the array, write priority, bypass and read registers.
// TESTING
//  1. Reset, DEPTH=32: rst_n low 1 cycle, then high.
//     -> rdy rises exactly 32 cycles later; every address reads 0.
//  2. Single write: wa_en=1, wa_addr=5, wa_data=32'h0000_0007 at edge N, with rd_addr port 0 = 5 at edge N.
//     -> rd_data port 0 = 32'h7 after edge N (bypass); reads 7 on later reads.
//  3. Collision: wa_en=wm_en=1, addresses 9/9, wa_data=32'hAAAA_AAAA, wm_data=32'h5555_5555.
//     -> Entry 9 = 32'h5555_5555.
//     -> Next cycle, addresses 3/4: both entries written.
//  4. Reset mid-sweep: rst_n low at cycle 10 of INIT.
//     -> clr_idx restarts at 0; rdy rises 32 cycles after the release.
//     -> Writes issued during INIT have no effect (read back 0).
//  5. ZERO_REG_EN defined: wa_en=1, wa_addr=0, wa_data=32'h3.
//     -> rd_data = 0 on all ports, same edge and after.
//     -> Undefined build: reads 32'h3.
//  6. NUM_RD=4, all ports addressing 7 after entry 7 is written with 32'h18.
//     -> All four ports return 32'h18 one cycle later.

Source files
------------

// File: rtl/mips_regfile_pkg.sv
// Shared types and constants for the MIPS general-purpose register file.
// The optional hard-wired zero register is selected with the ZERO_REG_EN macro.
package mips_regfile_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Load-word opcode; the upstream decoder turns it into wm_en.
    localparam logic [5:0] LOAD_OPC = 6'b100011;

endpackage

// File: rtl/mips_regfile_clr.sv
// Post-reset clear sweep for the register file.
// Walks every entry once, then raises rdy and stays in RUN until the next reset.
module mips_regfile_clr
    import mips_regfile_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     clr_we,
    output logic [$clog2(DEPTH)-1:0] clr_idx,
    output logic                     rdy
);

    localparam int              AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]   LAST_IDX = AW'(DEPTH - 1);
    localparam logic [AW-1:0]   IDX_STEP = AW'(1'b1);

    state_t          state_q;
    state_t          state_d;
    logic [AW-1:0]   clr_idx_q;
    logic [AW-1:0]   clr_idx_d;
    logic            rdy_q;
    logic            rdy_d;

    // Next-state, sweep index and ready flag
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        rdy_d     = rdy_q;
        case (state_q)
            INIT: begin
                clr_idx_d = clr_idx_q + IDX_STEP;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = RUN;
                    rdy_d   = 1'b1;
                end else begin
                    state_d = INIT;
                    rdy_d   = 1'b0;
                end
            end
            RUN: begin
                state_d = RUN;
                rdy_d   = 1'b1;
            end
            default: begin
                state_d   = INIT;
                clr_idx_d = {AW{1'b0}};
                rdy_d     = 1'b0;
            end
        endcase
    end

    // State, sweep index and ready registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= INIT;
            clr_idx_q <= {AW{1'b0}};
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            rdy_q     <= rdy_d;
        end
    end

    assign clr_we  = (state_q == INIT);
    assign clr_idx = clr_idx_q;
    assign rdy     = rdy_q;

endmodule

// File: rtl/mips_regfile.sv
// General-purpose register file: NUM_RD registered read ports, ALU (A) and load (M) write ports.
// Define ZERO_REG_EN to hard-wire entry 0 to zero.
module mips_regfile
    import mips_regfile_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]  rd_addr,
    output logic [NUM_RD*DATA_W-1:0]         rd_data,
    input  logic                             wa_en,
    input  logic [$clog2(DEPTH)-1:0]         wa_addr,
    input  logic [DATA_W-1:0]                wa_data,
    input  logic                             wm_en,
    input  logic [$clog2(DEPTH)-1:0]         wm_addr,
    input  logic [DATA_W-1:0]                wm_data,
    output logic                             rdy
);

    localparam int                AW        = $clog2(DEPTH);
    localparam logic [DATA_W-1:0] ZERO_WORD = {DATA_W{1'b0}};

    logic [DATA_W-1:0]        mem_q [DEPTH];
    logic [DATA_W-1:0]        mem_d [DEPTH];
    logic [NUM_RD*DATA_W-1:0] rd_data_q;
    logic [NUM_RD*DATA_W-1:0] rd_data_d;
    logic                     clr_we_s;
    logic [AW-1:0]            clr_idx_s;
    logic                     rdy_s;
    logic                     wa_hit_s;
    logic                     wm_hit_s;

    mips_regfile_clr #(
        .DEPTH   (DEPTH)
    ) u_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_we  (clr_we_s),
        .clr_idx (clr_idx_s),
        .rdy     (rdy_s)
    );

`ifdef ZERO_REG_EN
    assign wa_hit_s = wa_en && (wa_addr != {AW{1'b0}});
    assign wm_hit_s = wm_en && (wm_addr != {AW{1'b0}});
`else
    assign wa_hit_s = wa_en;
    assign wm_hit_s = wm_en;
`endif

    // Array next state: sweep clear during INIT, otherwise M takes priority over A
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_we_s) begin
                mem_d[i] = (AW'(i) == clr_idx_s) ? ZERO_WORD : mem_q[i];
            end else if (wm_hit_s && (AW'(i) == wm_addr)) begin
                mem_d[i] = wm_data;
            end else if (wa_hit_s && (AW'(i) == wa_addr)) begin
                mem_d[i] = wa_data;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Read data comes from the post-write array, giving write-first bypass
    always_comb begin
        rd_data_d = {(NUM_RD*DATA_W){1'b0}};
        for (int k = 0; k < NUM_RD; k++) begin
            if (clr_we_s) begin
                rd_data_d[k*DATA_W +: DATA_W] = ZERO_WORD;
`ifdef ZERO_REG_EN
            end else if (rd_addr[k*AW +: AW] == {AW{1'b0}}) begin
                rd_data_d[k*DATA_W +: DATA_W] = ZERO_WORD;
`endif
            end else begin
                rd_data_d[k*DATA_W +: DATA_W] = mem_d[rd_addr[k*AW +: AW]];
            end
        end
    end

    // Storage array; a write on a reset edge is discarded
    always_ff @(posedge clk) begin
        if (rst_n) begin
            mem_q <= mem_d;
        end
    end

    // Read data registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_data_q <= {(NUM_RD*DATA_W){1'b0}};
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
    assign rdy     = rdy_s;

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile (DEPTH=32, NUM_RD=4): directed table, reset sequences
// and randomized traffic checked against a behavioural model of the register file.
module tb_mips_regfile;
    import mips_regfile_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 4;
    localparam int AW     = 5;

`ifdef ZERO_REG_EN
    localparam bit          ZR  = 1'b1;
    localparam logic [31:0] E3  = 32'h0000_0000;
    localparam logic [31:0] EDB = 32'h0000_0000;
`else
    localparam bit          ZR  = 1'b0;
    localparam logic [31:0] E3  = 32'h0000_0003;
    localparam logic [31:0] EDB = 32'hDEAD_BEEF;
`endif

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic [NUM_RD*AW-1:0]     rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic                     wa_en;
    logic [AW-1:0]            wa_addr;
    logic [DATA_W-1:0]        wa_data;
    logic                     wm_en;
    logic [AW-1:0]            wm_addr;
    logic [DATA_W-1:0]        wm_data;
    logic                     rdy;
    logic [5:0]               opcode;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] mdl_mem [DEPTH];
    logic [DATA_W-1:0] mdl_rd  [NUM_RD];
    bit                mdl_rdy = 1'b0;
    int                mdl_cnt = 0;

    typedef struct {
        logic                     wa_en;
        logic [AW-1:0]            wa_addr;
        logic [DATA_W-1:0]        wa_data;
        logic                     wm_en;
        logic [AW-1:0]            wm_addr;
        logic [DATA_W-1:0]        wm_data;
        logic [NUM_RD*AW-1:0]     ra;
        logic [NUM_RD*DATA_W-1:0] ex;
    } vec_t;

    vec_t vecs[$];

    mips_regfile #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NUM_RD  (NUM_RD)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wa_en   (wa_en),
        .wa_addr (wa_addr),
        .wa_data (wa_data),
        .wm_en   (wm_en),
        .wm_addr (wm_addr),
        .wm_data (wm_data),
        .rdy     (rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference behaviour at one rising edge, from the register-file rules.
    task automatic model_edge();
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 32'h0;
            for (int k = 0; k < NUM_RD; k++) mdl_rd[k] = 32'h0;
            mdl_cnt = 0;
            mdl_rdy = 1'b0;
        end else if (!mdl_rdy) begin
            mdl_cnt++;
            if (mdl_cnt == DEPTH) mdl_rdy = 1'b1;
            for (int k = 0; k < NUM_RD; k++) mdl_rd[k] = 32'h0;
        end else begin
            if (wa_en && !(ZR && wa_addr == 5'd0)) mdl_mem[wa_addr] = wa_data;
            if (wm_en && !(ZR && wm_addr == 5'd0)) mdl_mem[wm_addr] = wm_data;
            for (int k = 0; k < NUM_RD; k++) mdl_rd[k] = mdl_mem[rd_addr[k*AW +: AW]];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model_rdy", {31'b0, rdy}, {31'b0, mdl_rdy});
        for (int k = 0; k < NUM_RD; k++)
            check($sformatf("model_rd_p%0d", k), rd_data[k*DATA_W +: DATA_W], mdl_rd[k]);
    endtask

    task automatic idle();
        wa_en = 1'b0; wa_addr = 5'd0; wa_data = 32'h0;
        wm_en = 1'b0; wm_addr = 5'd0; wm_data = 32'h0;
        opcode = 6'b000000;
    endtask

    task automatic rand_ops();
        opcode  = ($urandom_range(0, 1) == 1) ? LOAD_OPC : 6'b000000;
        wm_en   = (opcode == LOAD_OPC);
        wa_en   = ($urandom_range(0, 1) == 1);
        wa_addr = AW'($urandom_range(0, 7));
        wm_addr = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, DEPTH-1));
        wa_data = $urandom();
        wm_data = $urandom();
        for (int k = 0; k < NUM_RD; k++) rd_addr[k*AW +: AW] = AW'($urandom_range(0, DEPTH-1));
    endtask

    // Count edges from reset release until rdy, issuing writes that must be ignored.
    task automatic wait_rdy(input string name);
        int n = 0;
        while (rdy !== 1'b1 && n < 200) begin
            rand_ops();
            tick();
            n++;
        end
        idle();
        check(name, 32'(n), 32'd32);
    endtask

    task automatic sweep_zero();
        for (int a = 0; a < DEPTH / NUM_RD; a++) begin
            for (int k = 0; k < NUM_RD; k++) rd_addr[k*AW +: AW] = AW'(a*NUM_RD + k);
            tick();
            for (int k = 0; k < NUM_RD; k++)
                check($sformatf("sweep_zero_a%0d", a*NUM_RD + k), rd_data[k*DATA_W +: DATA_W], 32'h0);
        end
    endtask

    task automatic add_vec(input logic ae, input logic [AW-1:0] aa, input logic [31:0] ad,
                           input logic me, input logic [AW-1:0] ma, input logic [31:0] md,
                           input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                           input logic [AW-1:0] r2, input logic [AW-1:0] r3,
                           input logic [31:0] e0, input logic [31:0] e1,
                           input logic [31:0] e2, input logic [31:0] e3);
        vec_t v;
        v.wa_en = ae; v.wa_addr = aa; v.wa_data = ad;
        v.wm_en = me; v.wm_addr = ma; v.wm_data = md;
        v.ra = {r3, r2, r1, r0};
        v.ex = {e3, e2, e1, e0};
        vecs.push_back(v);
    endtask

    initial begin
        add_vec(1, 5, 32'h0000_0007, 0, 0, 32'h0, 5, 5, 5, 5, 32'h7, 32'h7, 32'h7, 32'h7);
        add_vec(0, 0, 32'h0, 0, 0, 32'h0, 5, 0, 1, 5, 32'h7, 32'h0, 32'h0, 32'h7);
        add_vec(1, 9, 32'hAAAA_AAAA, 1, 9, 32'h5555_5555, 9, 9, 5, 2,
                32'h5555_5555, 32'h5555_5555, 32'h7, 32'h0);
        add_vec(1, 3, 32'h1111_1111, 1, 4, 32'h2222_2222, 3, 4, 9, 9,
                32'h1111_1111, 32'h2222_2222, 32'h5555_5555, 32'h5555_5555);
        add_vec(0, 0, 32'h0, 0, 0, 32'h0, 3, 4, 9, 5,
                32'h1111_1111, 32'h2222_2222, 32'h5555_5555, 32'h7);
        add_vec(1, 0, 32'h0000_0003, 0, 0, 32'h0, 0, 0, 0, 0, E3, E3, E3, E3);
        add_vec(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 0, E3, E3, E3, E3);
        add_vec(1, 7, 32'h0000_0018, 0, 0, 32'h0, 1, 2, 3, 4,
                32'h0, 32'h0, 32'h1111_1111, 32'h2222_2222);
        add_vec(0, 0, 32'h0, 0, 0, 32'h0, 7, 7, 7, 7, 32'h18, 32'h18, 32'h18, 32'h18);
        add_vec(0, 0, 32'h0, 1, 0, 32'hDEAD_BEEF, 0, 0, 7, 0, EDB, EDB, 32'h18, EDB);
        add_vec(1, 12, 32'h1, 0, 12, 32'h2, 12, 12, 7, 0, 32'h1, 32'h1, 32'h18, EDB);
        add_vec(0, 12, 32'h1, 1, 12, 32'h2, 12, 12, 12, 3, 32'h2, 32'h2, 32'h2, 32'h1111_1111);

        // Reset with a write presented on the reset edge, then the full sweep.
        rst_n   = 1'b0;
        rd_addr = '0;
        rand_ops();
        tick();
        check("reset_rdy", {31'b0, rdy}, 32'h0);
        for (int k = 0; k < NUM_RD; k++)
            check($sformatf("reset_rd_p%0d", k), rd_data[k*DATA_W +: DATA_W], 32'h0);
        rst_n = 1'b1;
        wait_rdy("rdy_latency");
        sweep_zero();

        // Reset during the sweep restarts it; INIT-time writes never land.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            rand_ops();
            tick();
        end
        rst_n = 1'b0;
        rand_ops();
        tick();
        rst_n = 1'b1;
        wait_rdy("rdy_latency_mid_sweep");
        sweep_zero();

        for (int i = 0; i < vecs.size(); i++) begin
            wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
            wm_en = vecs[i].wm_en; wm_addr = vecs[i].wm_addr; wm_data = vecs[i].wm_data;
            rd_addr = vecs[i].ra;
            tick();
            for (int k = 0; k < NUM_RD; k++)
                check($sformatf("vec%0d_p%0d", i, k), rd_data[k*DATA_W +: DATA_W],
                      vecs[i].ex[k*DATA_W +: DATA_W]);
        end
        idle();

        for (int c = 0; c < 300; c++) begin
            rand_ops();
            tick();
        end
        rst_n = 1'b0;
        rand_ops();
        tick();
        rst_n = 1'b1;
        wait_rdy("rdy_latency_random");
        for (int c = 0; c < 300; c++) begin
            rand_ops();
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
